// File: rtl/mdio_frame_engine.sv
// Clause-45 MDIO master: serialises one command onto MDC/MDIO and returns read data and status.
// Optional Clause-22 framing (cmd_c22 port) is enabled by defining MDIO_CLAUSE22_EN.
module mdio_frame_engine #(
  parameter int CLK_DIV  = 50,
  parameter int PRE_BITS = 32
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_prtad,
  input  logic [4:0]  cmd_devad,
  input  logic [15:0] cmd_data,
`ifdef MDIO_CLAUSE22_EN
  input  logic        cmd_c22,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_TA   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;

  localparam logic [9:0] DIV_TC     = 10'(CLK_DIV - 1);
  localparam logic [6:0] HDR_START  = 7'(PRE_BITS);
  localparam logic [6:0] TA_START   = 7'(PRE_BITS + 14);
  localparam logic [6:0] TA_SECOND  = 7'(PRE_BITS + 15);
  localparam logic [6:0] DATA_START = 7'(PRE_BITS + 16);
  localparam logic [6:0] LAST_BIT   = 7'(PRE_BITS + 31);
  localparam logic [6:0] PRE_SHIFT  = 7'(32 - PRE_BITS);

  logic [2:0]  r_state;
  logic [9:0]  r_div;
  logic [6:0]  r_bit;
  logic        r_mdc;
  logic        r_mdio_o;
  logic        r_mdio_t;
  logic [62:0] r_shift;
  logic        r_rd_op;
  logic [15:0] r_rd;
  logic        r_ta_err;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;

  logic [1:0]  w_st;
  logic        w_illegal;
  logic [63:0] w_load;
  logic        w_tc;
  logic [6:0]  w_bit_nx;
  logic [2:0]  w_state_nx;
  logic [2:0]  w_first;

`ifdef MDIO_CLAUSE22_EN
  // Clause-22 uses ST=01 and only has write (01) and read (10) opcodes.
  assign w_st      = cmd_c22 ? 2'b01 : 2'b00;
  assign w_illegal = cmd_c22 && (cmd_op == 2'b00 || cmd_op == 2'b11);
`else
  assign w_st      = 2'b00;
  assign w_illegal = 1'b0;
`endif

  // Frame is left-aligned so the first bit to send is always bit 63, whatever PRE_BITS is.
  assign w_load = {32'hFFFF_FFFF, w_st, cmd_op, cmd_prtad, cmd_devad, 2'b10, cmd_data} << PRE_SHIFT;

  function automatic logic [2:0] state_of(input logic [6:0] b);
    if (b < HDR_START)       return S_PRE;
    else if (b < TA_START)   return S_HDR;
    else if (b < DATA_START) return S_TA;
    else                     return S_DATA;
  endfunction

  assign w_tc       = (r_div == DIV_TC);
  assign w_bit_nx   = r_bit + 7'd1;
  assign w_state_nx = state_of(w_bit_nx);
  assign w_first    = state_of(7'd0);

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_mdc       <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_t    <= 1'b1;
      r_shift     <= '0;
      r_rd_op     <= 1'b0;
      r_rd        <= '0;
      r_ta_err    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div <= '0;
        r_bit <= '0;
        r_mdc <= 1'b0;
        if (cmd_valid) begin
          if (w_illegal) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_state  <= w_first;
            r_shift  <= w_load[62:0];
            r_mdio_o <= w_load[63];
            r_mdio_t <= 1'b0;
            r_rd_op  <= cmd_op[1];
            r_rd     <= '0;
            r_ta_err <= 1'b0;
          end
        end
      end else begin
        if (w_tc) begin
          r_div <= '0;
          r_mdc <= ~r_mdc;
        end else begin
          r_div <= r_div + 10'd1;
        end
        // Rising MDC edge: sample point for turnaround and read data.
        if (w_tc && !r_mdc) begin
          if (r_state == S_TA && r_bit == TA_SECOND) r_ta_err <= mdio_i;
          if (r_state == S_DATA)                     r_rd     <= {r_rd[14:0], mdio_i};
        end
        // Falling MDC edge: advance to the next bit or close the frame.
        if (w_tc && r_mdc) begin
          if (r_bit == LAST_BIT) begin
            r_state     <= S_IDLE;
            r_bit       <= '0;
            r_mdio_o    <= 1'b1;
            r_mdio_t    <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rd_op ? r_rd : 16'h0000;
            r_rsp_err   <= r_rd_op & r_ta_err;
          end else begin
            r_bit    <= w_bit_nx;
            r_shift  <= {r_shift[61:0], 1'b1};
            r_mdio_o <= r_shift[62];
            r_state  <= w_state_nx;
            if (w_state_nx == S_TA && r_rd_op) r_mdio_t <= 1'b1;
          end
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign mdc       = r_mdc;
  assign mdio_o    = r_mdio_o;
  assign mdio_t    = r_mdio_t;

endmodule

// File: tb/tb_mdio_frame_engine.sv
// Self-checking bench for mdio_frame_engine: vector table, scoreboard queue, PHY model on mdio_i.
module tb_mdio_frame_engine;

  localparam int CLK_DIV  = 2;
  localparam int PRE_BITS = 32;
  localparam int LATENCY  = (PRE_BITS + 32) * 2 * CLK_DIV;
  localparam logic [63:0] RD_MASK = {{46{1'b1}}, {18{1'b0}}};

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  prtad;
    logic [4:0]  devad;
    logic [15:0] data;
    logic [15:0] phy_data;
    logic        phy_present;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic        OPB_Clk, OPB_Rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_prtad, cmd_devad;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_t, mdio_i;
  logic [15:0] rsp_data;

  mdio_frame_engine #(.CLK_DIV(CLK_DIV), .PRE_BITS(PRE_BITS)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_prtad(cmd_prtad), .cmd_devad(cmd_devad), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge OPB_Clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: front entry is the frame currently on the wire.
  vec_t sb[$];

  function automatic logic phy_bit(input vec_t v, input int idx);
    if (!v.op[1] || !v.phy_present) return 1'b1;
    if (idx == 47) return 1'b0;
    if (idx >= 48 && idx <= 63) return v.phy_data[63 - idx];
    return 1'b1;
  endfunction

  // Monitor: decodes mdio_o on MDC rising edges, drives the PHY side, scores completions.
  logic [63:0] cap, exp_frame, mask;
  int   n_rise, mon_idx, start_cyc, n_rsp, rsp_cyc_prev, rsp_cyc_last;
  logic prev_mdc, prev_busy, t_bad, exp_t;
  vec_t e;

  initial begin
    cap = '0; n_rise = 0; mon_idx = 0; start_cyc = 0; n_rsp = 0;
    rsp_cyc_prev = 0; rsp_cyc_last = 0; prev_mdc = 1'b0; prev_busy = 1'b0; t_bad = 1'b0;
    mdio_i = 1'b1;
  end

  always @(negedge OPB_Clk) begin
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      rsp_cyc_prev = rsp_cyc_last;
      rsp_cyc_last = cyc;
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        exp_frame = {32'hFFFF_FFFF, 2'b00, e.op, e.prtad, e.devad, 2'b10, e.data};
        mask = e.op[1] ? RD_MASK : '1;
        check("rsp_data", rsp_data, e.exp_data);
        check("rsp_err", rsp_err, e.exp_err);
        check("frame_bits", cap & mask, exp_frame & mask);
        check("mdc_rising_count", n_rise, 64);
        check("mdio_t_profile", t_bad, 0);
        check("rsp_latency", cyc - start_cyc, LATENCY);
      end
    end
    if (busy && !prev_busy) begin
      start_cyc = cyc; cap = '0; n_rise = 0; t_bad = 1'b0; mon_idx = 0; prev_mdc = 1'b0;
    end
    if (busy) begin
      if (mdc && !prev_mdc) begin
        cap = {cap[62:0], mdio_o};
        n_rise++;
        exp_t = (sb.size() != 0) && sb[0].op[1] && (mon_idx >= 46);
        if (mdio_t !== exp_t) t_bad = 1'b1;
      end
      if (!mdc && prev_mdc) mon_idx++;
    end
    prev_mdc  = mdc;
    prev_busy = busy;
    mdio_i    = (sb.size() != 0 && busy) ? phy_bit(sb[0], mon_idx) : 1'b1;
  end

  task automatic drive(input vec_t v);
    cmd_op = v.op; cmd_prtad = v.prtad; cmd_devad = v.devad; cmd_data = v.data;
  endtask

  task automatic send(input vec_t v);
    int i;
    for (i = 0; i < 2000 && cmd_ready !== 1'b1; i++) @(negedge OPB_Clk);
    if (cmd_ready !== 1'b1) check("send_ready_timeout", 0, 1);
    drive(v);
    cmd_valid = 1'b1;
    sb.push_back(v);
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge OPB_Clk);
    check("completion_timeout", sb.size(), 0);
  endtask

  vec_t vecs[7];
  vec_t va, vb;
  int   rsp_before;

  initial begin
    vecs[0] = '{2'b01, 5'h01, 5'h1E, 16'hA5C3, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[1] = '{2'b00, 5'h1F, 5'h00, 16'h8001, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{2'b11, 5'h03, 5'h01, 16'h0000, 16'h1234, 1'b1, 16'h1234, 1'b0};
    vecs[3] = '{2'b10, 5'h10, 5'h07, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0};
    vecs[4] = '{2'b11, 5'h05, 5'h03, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b1};
    vecs[5] = '{2'b01, 5'h1F, 5'h1F, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[6] = '{2'b11, 5'h0A, 5'h15, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0};

    OPB_Rst_n = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_prtad = '0; cmd_devad = '0; cmd_data = '0;
    repeat (3) @(negedge OPB_Clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mdc", mdc, 0);
    check("rst_mdio_o", mdio_o, 1);
    check("rst_mdio_t", mdio_t, 1);
    OPB_Rst_n = 1'b1;
    repeat (4) begin
      @(negedge OPB_Clk);
      check("idle_mdc", mdc, 0);
      check("idle_cmd_ready", cmd_ready, 1);
    end

    // Table-driven frames, one at a time.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i]);
      wait_done();
    end

    // cmd_valid held through the frame with new fields; second command lands on the rsp_valid cycle.
    va = '{2'b01, 5'h12, 5'h04, 16'h5A5A, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vb = '{2'b11, 5'h07, 5'h1D, 16'h0000, 16'hC0DE, 1'b1, 16'hC0DE, 1'b0};
    @(negedge OPB_Clk);
    drive(va);
    cmd_valid = 1'b1;
    sb.push_back(va);
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    drive(vb);
    sb.push_back(vb);
    repeat (40) @(negedge OPB_Clk);
    check("busy_cmd_ready", cmd_ready, 0);
    check("busy_flag", busy, 1);
    for (int i = 0; i < 600 && cmd_ready !== 1'b1; i++) @(negedge OPB_Clk);
    check("b2b_rsp_valid_with_ready", rsp_valid, 1);
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    cmd_valid = 1'b0;
    check("b2b_second_accepted", busy, 1);
    check("b2b_mdio_driven", mdio_t, 0);
    wait_done();
    check("b2b_rsp_spacing", rsp_cyc_last - rsp_cyc_prev, LATENCY + 1);

    // Reset during the DATA phase of a read aborts without a response.
    send(vecs[2]);
    for (int i = 0; i < 2000 && mon_idx < 52; i++) @(negedge OPB_Clk);
    check("reach_data_phase", mon_idx >= 52, 1);
    @(posedge OPB_Clk);
    #2;
    OPB_Rst_n = 1'b0;
    sb.delete();
    rsp_before = n_rsp;
    #1;
    check("abort_mdc", mdc, 0);
    check("abort_mdio_t", mdio_t, 1);
    check("abort_busy", busy, 0);
    repeat (5) @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;
    repeat (300) @(negedge OPB_Clk);
    check("abort_no_rsp", n_rsp, rsp_before);
    send(vecs[0]);
    wait_done();
    send(vecs[3]);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdio_frame_engine.md
Name: mdio_frame_engine

Overview:
- Serial MDIO master stage directly downstream of the OPB-mapped SFP MDIO register controller.
- Accepts one Clause-45 command at a time from the controller's register file, serialises it onto MDC/MDIO toward the SFP+ PHY pins on mgt_gpio, and returns read data and a status pulse.
- Owns all MDC clock generation, bit timing, tristate control and turnaround sampling.

Parameters:
- CLK_DIV, 50, OPB_Clk cycles per MDC half-period; legal range 2..1023.
- PRE_BITS, 32, preamble length in bits (all ones); legal range 0..32.

Ports:
- OPB_Clk  input  1  sole clock
- OPB_Rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high in IDLE only
- cmd_op  input  2  00 address, 01 write, 11 read, 10 read-post-increment
- cmd_prtad  input  5  port address
- cmd_devad  input  5  device address
- cmd_data  input  16  address or write data; ignored for reads
- rsp_valid  output  1  one-cycle completion pulse
- rsp_data  output  16  captured read data; 0 for address/write
- rsp_err  output  1  valid with rsp_valid; no PHY drove TA low
- busy  output  1  frame in progress
- mdc  output  1  MDIO clock
- mdio_o  output  1  MDIO drive value
- mdio_t  output  1  tristate enable, 1 = released/input
- mdio_i  input  1  MDIO pin sample

Behaviour:
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, mdc=0, mdio_o=1, mdio_t=1. Reset mid-frame aborts immediately; no rsp_valid is generated.
- Accept on the rising edge with cmd_valid&&cmd_ready. Command fields latch into a 64-bit shift register:
  - PRE_BITS ones
  - ST=00, OP, PRTAD, DEVAD
  - TA=10
  - 16 data bits, MSB first
- Next cycle: cmd_ready=0, busy=1, mdio_t=0, mdio_o=first bit.
- cmd_valid while busy is ignored and produces no queueing.
- Bit timing:
  - A divider counter runs 0..CLK_DIV-1.
  - At each terminal count, mdc toggles.
  - Each bit lasts 2*CLK_DIV cycles: mdc low phase, then high phase.
  - mdc rising edge is the sample point.
  - On mdc falling edge, the shifter advances and mdio_o presents the next bit.
  - mdio_o changes only with mdc low.
- States and transitions:
  - IDLE -> PRE (skipped if PRE_BITS=0)
  - PRE -> HDR (14 bits: ST, OP, PRTAD, DEVAD)
  - HDR -> TA (2 bits)
  - TA -> DATA (16 bits)
  - DATA -> DONE -> IDLE
- TA handling:
  - Address/write: TA driven as 1,0.
  - Read/read-inc: mdio_t=1 from the first TA bit through end of DATA.
  - mdio_i is sampled on the 2nd TA rising edge; a value of 1 sets rsp_err=1.
  - DATA bits are sampled on each rising edge into rsp_data, MSB first.
- Completion:
  - After the final DATA bit's falling edge: mdc=0, mdio_t=1, mdio_o=1.
  - rsp_valid pulses high exactly (PRE_BITS+32)*2*CLK_DIV cycles after the accept edge.
  - cmd_ready returns high in the same cycle as the rsp_valid pulse, so back-to-back commands are allowed.
- rsp_data and rsp_err hold their last values until the next completion.
- rsp_err is always 0 for address/write.
- Divider and bit counter wrap only within a frame; both are cleared in IDLE.

Optional Feature:
- Macro: MDIO_CLAUSE22_EN.
- When defined:
  - Adds input port cmd_c22 (1 bit), latched at accept.
  - When cmd_c22=1: ST=01, cmd_op 01 = write and 10 = read, cmd_devad carries REGAD. Ops 00/11 with cmd_c22=1 complete immediately with rsp_valid and rsp_err=1, and no MDC activity.
- When undefined: no cmd_c22 port; only Clause-45 frames are generated.

Test Plan:
- Reset: hold OPB_Rst_n=0 -> all outputs at reset values. Release -> mdc stays 0 and cmd_ready=1.
- Write, CLK_DIV=2, PRE_BITS=32, op=01, prtad=0x01, devad=0x1E, data=0xA5C3:
  - Decoding mdio_o on mdc rising edges gives 32 ones then 00 01 00001 11110 10 1010010111000011.
  - rsp_valid pulses at cycle 256 after accept with rsp_err=0.
- Read, op=11: PHY model drives mdio_i=0 at TA bit 2, then 0x1234.
  - mdio_t=1 from TA onward.
  - rsp_data=0x1234, rsp_err=0.
- No-PHY read: mdio_i pulled to 1 throughout -> rsp_err=1, rsp_data=0xFFFF.
- Busy and back-to-back:
  - cmd_valid held mid-frame -> cmd_ready=0, frame unchanged.
  - Second command accepted in the rsp_valid cycle -> next preamble starts without an extra idle bit.
- Reset mid-frame: assert OPB_Rst_n low during DATA -> next cycle mdc=0, mdio_t=1, no rsp_valid. A subsequent command completes normally.
